auto_reclose_controller: RTL
============================

AUTO_RECLOSE_CONTROLLER -- requirements
Module: auto_reclose_controller

Interface
REQ-001 SHALL have parameter DEAD_TIME, default 400, cycles breaker stays open before a reclose attempt (0.5 s).
REQ-002 SHALL have parameter RECLAIM_TIME, default 2400, cycles a reclose must hold before the sequence resets (3 s).
REQ-003 SHALL have parameter MAX_SHOTS, default 3, maximum reclose attempts before lockout (1..7).
REQ-004 SHALL have parameter CB_TIMEOUT, default 80, cycles allowed for breaker status to confirm a command (100 ms).
REQ-005 SHALL have ports:
- clk_800hz  in  1  clock; all logic on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- trip_signal  in  1  overcurrent trip request from the relay.
- cb_closed  in  1  breaker auxiliary contact, 1 = closed.
- lockout_clr  in  1  operator lockout acknowledge, 1-cycle pulse.
- cb_open_cmd  out  1  breaker open command.
- cb_close_cmd  out  1  breaker close command.
- shot_count  out  3  recloses used in the current sequence.
- lockout  out  1  high while in LOCKOUT.
- bf_alarm  out  1  sticky breaker-failure alarm.
- state  out  3  current FSM state encoding, for debug.

Function
REQ-006 SHALL implement FSM states IDLE, TRIP, DEAD, CLOSE, RECLAIM and LOCKOUT, with all outputs registered (Moore).
REQ-007 IDLE: trip_signal=1 SHALL move to TRIP on the next edge.
REQ-008 TRIP: cb_open_cmd=1; cb_closed=0 SHALL move to LOCKOUT if shot_count==MAX_SHOTS, else to DEAD with shot_count incremented.
REQ-009 DEAD: SHALL count exactly DEAD_TIME cycles, ignore trip_signal, then move to CLOSE.
REQ-010 CLOSE: cb_close_cmd=1; cb_closed=1 SHALL move to RECLAIM; if cb_closed stays 0 for CB_TIMEOUT cycles, SHALL move to LOCKOUT.
REQ-011 RECLAIM: trip_signal=1 SHALL move to TRIP; after RECLAIM_TIME cycles without a trip, SHALL move to IDLE and clear shot_count.
REQ-012 RECLAIM: trip_signal=1 on the same cycle the timer expires SHALL take precedence (go to TRIP).
REQ-013 LOCKOUT: cb_open_cmd=1 and lockout=1; lockout_clr=1 with trip_signal=0 SHALL move to IDLE with shot_count cleared.
REQ-014 LOCKOUT: lockout_clr is ignored while trip_signal=1.
REQ-015 cb_open_cmd and cb_close_cmd SHALL never both be 1.
REQ-016 Timers SHALL be 16-bit, reload to 0 on every state entry and saturate, never wrapping.
REQ-017 shot_count SHALL never exceed MAX_SHOTS.

Reset
REQ-018 reset SHALL force state IDLE, all timers 0, and all outputs 0, including bf_alarm.
REQ-019 reset asserted mid-sequence SHALL abandon the sequence immediately; the first state after release SHALL be IDLE.

Configuration
REQ-020 With macro BREAKER_FAIL_EN defined, if cb_closed stays 1 for CB_TIMEOUT cycles in TRIP, then:
- bf_alarm SHALL set (sticky until reset);
- the FSM SHALL move to LOCKOUT.
REQ-021 Without BREAKER_FAIL_EN, TRIP SHALL wait indefinitely for cb_closed=0, and bf_alarm SHALL be tied to 0.

Structure
REQ-022 Shared package relay_pkg SHALL hold:
- the state encoding constants;
- the default timing constants;
- the 16-bit timer width.
REQ-023 A sub-module relay_timer SHALL be used for the timers:
- inputs: clear and enable;
- outputs: 16-bit count and a done flag against a parameter limit.

Verification (DEAD_TIME=4, RECLAIM_TIME=8, MAX_SHOTS=2, CB_TIMEOUT=5)
REQ-024 Successful reclose:
- stimulus: trip pulse in IDLE; cb_closed follows the commands; no further trip;
- response: TRIP -> DEAD (4 cycles) -> CLOSE -> RECLAIM (8 cycles) -> IDLE, with shot_count going 1 then 0.
REQ-025 Permanent fault:
- stimulus: trip_signal held 1;
- response: two reclose attempts, then LOCKOUT with shot_count=2, lockout=1, cb_open_cmd=1.
REQ-026 Simultaneous events:
- stimulus: trip on the RECLAIM expiry cycle;
- response: next state TRIP, not IDLE.
REQ-027 Close failure:
- stimulus: cb_closed held 0 in CLOSE;
- response: LOCKOUT after 5 cycles; lockout_clr with trip_signal=0 -> IDLE with shot_count=0.
REQ-028 Breaker failure with BREAKER_FAIL_EN:
- stimulus: cb_closed held 1 in TRIP;
- response: after 5 cycles bf_alarm=1 and LOCKOUT;
- without the macro, the FSM stays in TRIP and bf_alarm=0.
REQ-029 Reset mid-sequence:
- stimulus: reset in DEAD at timer count 2;
- response: next cycle IDLE, all outputs 0.

Source files
------------

// File: rtl/relay_pkg.sv
// Shared definitions for the auto-reclose relay: FSM state encoding,
// default timing constants (800 Hz clock) and the timer width.
package relay_pkg;

  localparam int TIMER_W = 16;

  // Default timing at 800 Hz
  localparam int DEAD_TIME_DEF    = 400;   // 0.5 s open before reclose
  localparam int RECLAIM_TIME_DEF = 2400;  // 3 s hold before sequence reset
  localparam int MAX_SHOTS_DEF    = 3;
  localparam int CB_TIMEOUT_DEF   = 80;    // 100 ms breaker confirm window

  // FSM state encoding, also driven out on the debug state port
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_TRIP    = 3'd1;
  localparam logic [2:0] ST_DEAD    = 3'd2;
  localparam logic [2:0] ST_CLOSE   = 3'd3;
  localparam logic [2:0] ST_RECLAIM = 3'd4;
  localparam logic [2:0] ST_LOCKOUT = 3'd5;

  // Count value seen on the last cycle of a LIMIT-cycle dwell that starts at 0.
  function automatic logic [TIMER_W-1:0] last_count(input int limit);
    if (limit <= 1) return '0;
    return TIMER_W'(limit - 1);
  endfunction

endpackage

// File: rtl/relay_timer.sv
// Saturating 16-bit dwell timer. clear reloads to 0, enable advances,
// done is high on the LIMIT-th cycle after a clear and stays high.
module relay_timer
  import relay_pkg::*;
#(
  parameter int LIMIT = CB_TIMEOUT_DEF
) (
  input  logic               clk_800hz,
  input  logic               clear,
  input  logic               enable,
  output logic [TIMER_W-1:0] count,
  output logic               done
);

  localparam logic [TIMER_W-1:0] CNT_MAX = '1;
  localparam logic [TIMER_W-1:0] LAST    = last_count(LIMIT);

  // Count up while enabled, holding at full scale instead of wrapping
  always_ff @(posedge clk_800hz) begin
    if (clear)
      count <= '0;
    else if (enable && (count != CNT_MAX))
      count <= count + 1'b1;
  end

  assign done = (count >= LAST);

endmodule

// File: rtl/auto_reclose_controller.sv
// Auto-reclose controller for a feeder breaker: trip, dead time, reclose,
// reclaim, with lockout after MAX_SHOTS attempts or a failed close.
// Optional feature: define BREAKER_FAIL_EN to raise a sticky bf_alarm and
// lock out when the breaker does not open within CB_TIMEOUT in TRIP.
module auto_reclose_controller
  import relay_pkg::*;
#(
  parameter int DEAD_TIME    = DEAD_TIME_DEF,
  parameter int RECLAIM_TIME = RECLAIM_TIME_DEF,
  parameter int MAX_SHOTS    = MAX_SHOTS_DEF,
  parameter int CB_TIMEOUT   = CB_TIMEOUT_DEF
) (
  input  logic       clk_800hz,
  input  logic       reset,
  input  logic       trip_signal,
  input  logic       cb_closed,
  input  logic       lockout_clr,
  output logic       cb_open_cmd,
  output logic       cb_close_cmd,
  output logic [2:0] shot_count,
  output logic       lockout,
  output logic       bf_alarm,
  output logic [2:0] state
);

  localparam logic [2:0]         MAX_SHOT_L   = 3'(MAX_SHOTS);
  localparam logic [TIMER_W-1:0] DEAD_LAST    = last_count(DEAD_TIME);
  localparam logic [TIMER_W-1:0] RECLAIM_LAST = last_count(RECLAIM_TIME);

  logic [2:0]         state_next;
  logic [2:0]         shot_next;
  logic               tmr_clear;
  logic [TIMER_W-1:0] tmr_cnt;
  logic               cb_timeout;
`ifdef BREAKER_FAIL_EN
  logic               bf_set;
`endif

  // One dwell timer serves every state: it restarts on each state entry,
  // its count times DEAD/RECLAIM and its done flag is the breaker timeout.
  assign tmr_clear = reset | (state_next != state);

  relay_timer #(.LIMIT(CB_TIMEOUT)) u_dwell_timer (
    .clk_800hz (clk_800hz),
    .clear     (tmr_clear),
    .enable    (state != ST_IDLE),
    .count     (tmr_cnt),
    .done      (cb_timeout)
  );

  // Next-state and shot-count decode
  always_comb begin
    state_next = state;
    shot_next  = shot_count;
`ifdef BREAKER_FAIL_EN
    bf_set     = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (trip_signal) state_next = ST_TRIP;
      end
      ST_TRIP: begin
        if (!cb_closed) begin
          if (shot_count >= MAX_SHOT_L) begin
            state_next = ST_LOCKOUT;
          end else begin
            state_next = ST_DEAD;
            shot_next  = shot_count + 3'd1;
          end
        end
`ifdef BREAKER_FAIL_EN
        else if (cb_timeout) begin
          state_next = ST_LOCKOUT;
          bf_set     = 1'b1;
        end
`endif
      end
      ST_DEAD: begin
        if (tmr_cnt >= DEAD_LAST) state_next = ST_CLOSE;
      end
      ST_CLOSE: begin
        if (cb_closed)       state_next = ST_RECLAIM;
        else if (cb_timeout) state_next = ST_LOCKOUT;
      end
      ST_RECLAIM: begin
        // A trip on the expiry cycle wins over returning to IDLE
        if (trip_signal) begin
          state_next = ST_TRIP;
        end else if (tmr_cnt >= RECLAIM_LAST) begin
          state_next = ST_IDLE;
          shot_next  = '0;
        end
      end
      ST_LOCKOUT: begin
        if (lockout_clr && !trip_signal) begin
          state_next = ST_IDLE;
          shot_next  = '0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        shot_next  = '0;
      end
    endcase
  end

  // State, shot count and Moore outputs, all registered from the next state
  always_ff @(posedge clk_800hz) begin
    if (reset) begin
      state        <= ST_IDLE;
      shot_count   <= '0;
      cb_open_cmd  <= 1'b0;
      cb_close_cmd <= 1'b0;
      lockout      <= 1'b0;
    end else begin
      state        <= state_next;
      shot_count   <= shot_next;
      cb_open_cmd  <= (state_next == ST_TRIP) || (state_next == ST_LOCKOUT);
      cb_close_cmd <= (state_next == ST_CLOSE);
      lockout      <= (state_next == ST_LOCKOUT);
    end
  end

`ifdef BREAKER_FAIL_EN
  // Breaker-failure alarm latches until reset
  always_ff @(posedge clk_800hz) begin
    if (reset)       bf_alarm <= 1'b0;
    else if (bf_set) bf_alarm <= 1'b1;
  end
`else
  assign bf_alarm = 1'b0;
`endif

endmodule
